// File: rtl/register_file_mp.sv
// Multi-port integer register file: NRD combinational reads, two write ports, pending-write scoreboard, sweep clear.
// Latency: reads are zero-latency, writes are visible the cycle after commit, and a clear sweep takes NREGS cycles.
// Backpressure: none. Writes, issues and clr_req are dropped while clr_busy is high. Optional macro: REGFILE_BYPASS_EN.
module register_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [XLEN-1:0]       wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [XLEN-1:0]       wdata1,
    input  logic                  issue_valid,
    input  logic [ADDR_W-1:0]     issue_rd,
    output logic [NREGS-1:0]      pend,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t                  state_q;
    logic [ADDR_W-1:0]       cnt_q;
    logic                    clr_busy_q;
    logic [XLEN-1:0]         regs_q [NREGS];
    logic [NREGS-1:0]        pend_q, pend_d;
    logic                    sweeping;
    logic                    commit0, commit1;
    logic [ADDR_W-1:0]       ra;
    logic [XLEN-1:0]         rval;

    assign sweeping = (state_q == SWEEP);

    // Port 1 is the newer producer, so a same-address port-0 write is dropped.
    assign commit1 = we1 && (waddr1 != '0) && !sweeping;
    assign commit0 = we0 && (waddr0 != '0) && !sweeping && !(commit1 && (waddr1 == waddr0));

    // Clear FSM: the counter walks every entry once, starting from 0 on each new sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q    <= SWEEP;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = clr_busy_q;

    // Storage array: the sweep owns it while active, and the write ports own it otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (sweeping) begin
            regs_q[cnt_q] <= '0;
        end else begin
            if (commit0) regs_q[waddr0] <= wdata0;
            if (commit1) regs_q[waddr1] <= wdata1;
        end
    end

    // Scoreboard next state: commits clear, a new issue sets last so it wins, and any clear activity forces all-zero.
    always_comb begin
        pend_d = pend_q;
        if (commit0) pend_d[waddr0] = 1'b0;
        if (commit1) pend_d[waddr1] = 1'b0;
        if (issue_valid && (issue_rd != '0)) pend_d[issue_rd] = 1'b1;
        if (sweeping || clr_req) pend_d = '0;
        pend_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend = pend_q;

    // Read ports: x0 always reads zero, and the optional forward of same-cycle write data gives port 1 priority.
    always_comb begin
        rd_data = '0;
        ra      = '0;
        rval    = '0;
        for (int k = 0; k < NRD; k++) begin
            ra   = rd_addr[k*ADDR_W +: ADDR_W];
            rval = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (commit1 && (waddr1 == ra))
                rval = wdata1;
            else if (we0 && (waddr0 != '0) && !sweeping && (waddr0 == ra))
                rval = wdata0;
`endif
            if (ra == '0) rval = '0;
            rd_data[k*XLEN +: XLEN] = rval;
        end
    end

endmodule
